// File: rtl/branch_update_queue.sv
// In-order branch tracking queue: allocates at dispatch, resolves out of order, and retires in order into predictor training updates.
// Define BUQ_PERF_COUNTERS_EN to add the saturating perf_retired / perf_mispred counters.
module branch_update_queue #(
  parameter  int DEPTH = 8,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred,
  output logic [TAG_W-1:0] enq_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             flush,
  output logic             upd_w_en,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             empty
`ifdef BUQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]      perf_retired,
  output logic [31:0]      perf_mispred
`endif
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, resolved_q, pred_q, taken_q;
  logic [DEPTH-1:0] valid_d, resolved_d;
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [TAG_W-1:0] head_q, tail_q, head_d, tail_d, head_inc;
  logic [TAG_W:0]   count_q, count_d;
  logic             retire, mispred_retire, enq_fire, res_fire;

  // The head must already be resolved at the start of the cycle, so a same-cycle resolve never retires.
  assign retire         = valid_q[head_q] && resolved_q[head_q] && !flush;
  assign mispred_retire = retire && (taken_q[head_q] != pred_q[head_q]);
  assign enq_ready      = (count_q != FULL_CNT) && !flush && !mispred_retire;
  assign enq_fire       = enq_valid && enq_ready;
  assign res_fire       = res_valid && valid_q[res_tag] && !resolved_q[res_tag] && !flush;
  assign enq_tag        = tail_q;
  assign empty          = (count_q == '0);
  assign head_inc       = head_q + TAG_W'(1);

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (mispred_retire) begin
      // Everything younger than the mispredicted branch is on the wrong path.
      valid_d    = '0;
      resolved_d = '0;
      head_d     = head_inc;
      tail_d     = head_inc;
      count_d    = '0;
    end else begin
      if (res_fire) resolved_d[res_tag] = 1'b1;
      if (retire) begin
        valid_d[head_q]    = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_inc;
      end
      if (enq_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + TAG_W'(1);
      end
      case ({enq_fire, retire})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset; the valid/resolved bits qualify it.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_q[tail_q]   <= enq_pc;
      pred_q[tail_q] <= enq_pred;
    end
    if (res_fire) begin
      taken_q[res_tag]  <= res_taken;
      target_q[res_tag] <= res_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_w_en       <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      upd_w_en       <= retire;
      redirect_valid <= mispred_retire;
      if (retire) begin
        upd_pc    <= pc_q[head_q];
        upd_taken <= taken_q[head_q];
      end
      if (mispred_retire)
        redirect_pc <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
    end
  end

`ifdef BUQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_mispred <= '0;
    end else begin
      if (retire && (perf_retired != '1)) perf_retired <= perf_retired + 32'd1;
      if (mispred_retire && (perf_mispred != '1)) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: a list-based program-order model predicts each update; a negedge monitor checks them.
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk, rst;
  logic             enq_valid, enq_ready, enq_pred;
  logic [31:0]      enq_pc;
  logic [TAG_W-1:0] enq_tag, res_tag;
  logic             res_valid, res_taken, flush;
  logic [31:0]      res_target;
  logic             upd_w_en, upd_taken, redirect_valid, empty;
  logic [31:0]      upd_pc, redirect_pc;
`ifdef BUQ_PERF_COUNTERS_EN
  logic [31:0]      perf_retired, perf_mispred;
`endif

  branch_update_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_tag(enq_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .flush(flush),
    .upd_w_en(upd_w_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .empty(empty)
`ifdef BUQ_PERF_COUNTERS_EN
    , .perf_retired(perf_retired), .perf_mispred(perf_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] pc; logic pred; logic res; logic taken; logic [31:0] tgt; } ent_t;
  typedef struct { int due; logic [31:0] pc; logic taken; logic redir; logic [31:0] rpc; } exp_t;
  typedef struct { logic [31:0] pc; logic taken; logic redir; logic [31:0] rpc; } obs_t;

  ent_t mq[$];
  int   mhead;
  exp_t expq[$];
  obs_t obs[$];
  exp_t me;
  int   checks = 0, errors = 0;
  int   m_ret = 0, m_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (upd_w_en) begin
        obs.push_back('{upd_pc, upd_taken, redirect_valid, redirect_pc});
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update actual_pc=%h required=no_update", upd_pc);
        end else begin
          me = expq.pop_front();
          chk("upd_cycle", cyc, me.due);
          chk("upd_pc", upd_pc, me.pc);
          chk("upd_taken", upd_taken, me.taken);
          chk("redirect_valid", redirect_valid, me.redir);
          if (me.redir) chk("redirect_pc", redirect_pc, me.rpc);
        end
      end else begin
        chk("redirect_without_update", redirect_valid, 1'b0);
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          me = expq.pop_front();
          checks++; errors++;
          $display("FAIL missing_update actual=none required_pc=%h", me.pc);
        end
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs, advance the model.
  task automatic step(input logic ev, input logic [31:0] epc, input logic epred,
                      input logic rv, input logic [TAG_W-1:0] rtag, input logic rtk,
                      input logic [31:0] rtgt, input logic fl);
    bit ret, mis, rdy, fire;
    int k;
    ent_t t;
    enq_valid = ev; enq_pc = epc; enq_pred = epred;
    res_valid = rv; res_tag = rtag; res_taken = rtk; res_target = rtgt;
    flush = fl;
    #1;
    ret = !fl && mq.size() > 0 && mq[0].res;
    mis = ret && (mq[0].taken != mq[0].pred);
    rdy = (mq.size() != DEPTH) && !fl && !mis;
    chk("enq_ready", enq_ready, rdy);
    chk("empty", empty, mq.size() == 0);
    chk("enq_tag", enq_tag, (mhead + mq.size()) % DEPTH);
    fire = ev && rdy;
    if (fl) begin
      mq.delete();
      mhead = 0;
    end else begin
      if (ret) begin
        expq.push_back('{cyc + 1, mq[0].pc, mq[0].taken, mis,
                         mq[0].taken ? mq[0].tgt : mq[0].pc + 32'd4});
        m_ret++;
        if (mis) m_mis++;
      end
      if (mis) begin
        mq.delete();
        mhead = (mhead + 1) % DEPTH;
      end else begin
        k = (int'(rtag) + DEPTH - mhead) % DEPTH;
        if (rv && k < mq.size() && !mq[k].res) begin
          t = mq[k];
          t.res = 1'b1; t.taken = rtk; t.tgt = rtgt;
          mq[k] = t;
        end
        if (ret) begin
          void'(mq.pop_front());
          mhead = (mhead + 1) % DEPTH;
        end
        if (fire) mq.push_back('{epc, epred, 1'b0, 1'b0, 32'd0});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    enq_valid = 0; enq_pc = 0; enq_pred = 0; res_valid = 0; res_tag = 0;
    res_taken = 0; res_target = 0; flush = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); expq.delete(); obs.delete();
    mhead = 0; m_ret = 0; m_mis = 0;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    chk("rst_upd_w_en", upd_w_en, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_upd_taken", upd_taken, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);

    // single correctly predicted branch
    step(1, 32'h100, 1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 1, 32'h500, 0);
    idle(4);
    chk("t1_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("t1_pc", obs[0].pc, 32'h100);
      chk("t1_taken", obs[0].taken, 1);
      chk("t1_redir", obs[0].redir, 0);
    end

    // out-of-order resolve, in-order retire
    do_reset();
    step(1, 32'h200, 0, 0, 0, 0, 0, 0);
    step(1, 32'h204, 0, 0, 0, 0, 0, 0);
    step(1, 32'h208, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    idle(5);
    chk("t2_count", obs.size(), 3);
    if (obs.size() >= 3) begin
      chk("t2_pc0", obs[0].pc, 32'h200);
      chk("t2_pc1", obs[1].pc, 32'h204);
      chk("t2_pc2", obs[2].pc, 32'h208);
    end

    // mispredict taken: redirect to target, younger entry discarded
    do_reset();
    step(1, 32'h300, 0, 0, 0, 0, 0, 0);
    step(1, 32'h304, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 32'h400, 0);
    idle(2);
    chk("t3_empty", empty, 1);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    idle(4);
    chk("t3_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("t3_pc", obs[0].pc, 32'h300);
      chk("t3_redir", obs[0].redir, 1);
      chk("t3_rpc", obs[0].rpc, 32'h400);
    end

    // mispredict not-taken at top of address space wraps fall-through PC
    do_reset();
    step(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 32'h1234, 0);
    idle(3);
    chk("t4_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("t4_redir", obs[0].redir, 1);
      chk("t4_rpc", obs[0].rpc, 32'h0);
    end

    // fill to DEPTH, hold off ninth, tail wraps after one retire
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
    chk("t5_full_ready", enq_ready, 0);
    step(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    step(1, 32'h2000, 0, 1, 0, 0, 0, 0);
    step(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    chk("t5_ready_after", enq_ready, 1);
    chk("t5_tail_wrap", enq_tag, 0);
    step(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("t5_count", obs.size(), 1);

    // flush with three resolved entries pending
    do_reset();
    step(1, 32'h600, 0, 0, 0, 0, 0, 0);
    step(1, 32'h604, 0, 0, 0, 0, 0, 0);
    step(1, 32'h608, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    chk("t6_no_update", obs.size(), 0);
    chk("t6_empty", empty, 1);

    // async reset mid-cycle while an update pulse is being presented
    do_reset();
    step(1, 32'h700, 1, 0, 0, 0, 0, 0);
    step(1, 32'h704, 1, 1, 0, 1, 32'h800, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t7_pulse_seen", upd_w_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_upd_w_en", upd_w_en, 0);
    chk("t7_async_upd_pc", upd_pc, 0);
    chk("t7_async_empty", empty, 1);
    #1 rst = 1'b0;
    mq.delete(); expq.delete(); obs.delete(); mhead = 0; m_ret = 0; m_mis = 0;
    @(negedge clk);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic ev, ep, rv, rt, fl;
      logic [31:0] pc, tg;
      logic [TAG_W-1:0] tag;
      int k;
      ev = 1'($urandom % 2);
      pc = $urandom & 32'hFFFF_FFFC;
      ep = 1'($urandom % 2);
      rv = ($urandom % 3) != 0;
      tg = $urandom & 32'hFFFF_FFFC;
      if (mq.size() > 0 && ($urandom % 4) != 0) begin
        k   = int'($urandom % mq.size());
        tag = TAG_W'((mhead + k) % DEPTH);
        rt  = (($urandom % 5) == 0) ? !mq[k].pred : mq[k].pred;
      end else begin
        tag = TAG_W'($urandom % DEPTH);
        rt  = 1'($urandom % 2);
      end
      fl = ($urandom % 60) == 0;
      step(ev, pc, ep, rv, tag, rt, tg, fl);
    end
    idle(6);
    chk("expq_drained", expq.size(), 0);
`ifdef BUQ_PERF_COUNTERS_EN
    chk("perf_retired", perf_retired, m_ret);
    chk("perf_mispred", perf_mispred, m_mis);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
